// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage sequencer for a 16-bit async SRAM, two half-word phases per access.
// Optional one-entry last-word read buffer enabled by defining SRAM_LAST_WORD_EN.
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        last;
  logic [16:0] req_word;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign last     = (cnt_q == LAST);
  assign req_word = 17'((address - BASE_ADDR) >> 2);

`ifdef SRAM_LAST_WORD_EN
  logic        buf_vld_q;
  logic [16:0] buf_word_q;
  logic [31:0] buf_data_q;
  logic        hit;

  assign hit = MEM_R_EN & ~MEM_W_EN & buf_vld_q
             & (buf_word_q == req_word);

  // Remember the word touched by the last completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q  <= 1'b0;
      buf_word_q <= '0;
      buf_data_q <= '0;
    end else if (state_q == S_DONE) begin
      buf_vld_q  <= 1'b1;
      buf_word_q <= word_q;
      buf_data_q <= wr_q ? wdata_q : rdata_q;
    end
  end
`endif

  // State, phase counter and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic and SRAM pin drive for each phase.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    ready       = 1'b0;
    read_data   = rdata_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        ready = ~req;
`ifdef SRAM_LAST_WORD_EN
        if (hit) begin
          ready     = 1'b1;
          read_data = buf_data_q;
          rdata_d   = buf_data_q;
        end else
`endif
        if (req) begin
          word_d  = req_word;
          wdata_d = write_data;
          wr_d    = MEM_W_EN;
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end

      S_LOW: begin
        sram_addr = {word_q, 1'b0};
        if (wr_q) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
          sram_we_n   = last;
        end
        if (last) begin
          if (!wr_q) rdata_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (wr_q) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
          sram_we_n   = last;
        end
        if (last) begin
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
